booth_bcd_converter: RTL and testbench

Sequential signed-binary-to-BCD converter placed directly downstream of the Booth multiplier. It captures the multiplier's 8-bit two's-complement `result` and converts it by iterative shift-and-add-3 (double dabble) into a sign flag plus three BCD digits for the display/readout stage. A single-cycle `done` strobe marks a new value; the converted outputs hold until the next conversion completes.

---
 rtl/booth_bcd_converter.sv | 118 +++++++++++
 tb/tb_booth_bcd_converter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_bcd_converter.sv
// Signed 8-bit to sign + 3-digit BCD converter (shift-and-add-3, one shift per cycle).
// Sits behind the Booth multiplier and feeds the display/readout stage.
module booth_bcd_converter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] product,
  output logic       busy,
  output logic       done,
  output logic       sign,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [3:0] count,
  output logic       o_dbg_state
);

  // Handshake: start is a request sampled only while busy=0; done is a one-cycle
  // strobe after which sign/digits are valid and hold until the next completion.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [19:0] r_work;
  logic [19:0] w_adj;
  logic [19:0] w_shifted;
  logic [7:0]  w_mag;
  logic        w_last;
  logic [3:0]  r_count;
  logic        r_sign_cap;
  logic        r_sign;
  logic        r_done;
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // -128 maps to 8'h80 = 128 unsigned, so the magnitude never overflows.
  assign w_mag     = product[7] ? (~product + 8'd1) : product;
  assign w_adj     = {add3(r_work[19:16]), add3(r_work[15:12]), add3(r_work[11:8]), r_work[7:0]};
  assign w_shifted = w_adj << 1;
  assign w_last    = (r_count == 4'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work     <= 20'd0;
      r_count    <= 4'd0;
      r_sign_cap <= 1'b0;
      r_sign     <= 1'b0;
      r_done     <= 1'b0;
      r_hund     <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_cap <= product[7];
            r_work     <= {12'd0, w_mag};
            r_count    <= 4'd0;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          // The eighth shift publishes straight from the combinational result.
          if (w_last) begin
            r_count <= 4'd0;
            r_hund  <= w_shifted[19:16];
            r_tens  <= w_shifted[15:12];
            r_ones  <= w_shifted[11:8];
            r_sign  <= r_sign_cap;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count + 4'd1;
          end
        end
        default: r_count <= 4'd0;
      endcase
    end
  end

  always_comb begin
    busy         = (r_state == S_SHIFT);
    done         = r_done;
    sign         = r_sign;
    bcd_hundreds = r_hund;
    bcd_tens     = r_tens;
    bcd_ones     = r_ones;
    count        = r_count;
    o_dbg_state  = r_state;
  end

endmodule

// File: tb/tb_booth_bcd_converter.sv
// Directed bench for booth_bcd_converter: vector table plus hand-written
// sequences for busy-start, back-to-back and mid-conversion reset.
module tb_booth_bcd_converter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] product;
  logic       busy;
  logic       done;
  logic       sign;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [3:0] count;
  logic       o_dbg_state;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] product;
    logic       sign;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } vec_t;

  vec_t vecs[12];

  booth_bcd_converter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .sign         (sign),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .count        (count),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int s, input int h, input int t, input int o);
    chk({name, "_sign"}, int'(sign), s);
    chk({name, "_hund"}, int'(bcd_hundreds), h);
    chk({name, "_tens"}, int'(bcd_tens), t);
    chk({name, "_ones"}, int'(bcd_ones), o);
  endtask

  // One start pulse; samples after edges N..N+8 and checks the latency profile.
  task automatic run_vec(input vec_t v, input int idx);
    int    busy_n;
    int    done_at;
    int    cnt_bad;
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    start   = 1'b1;
    product = v.product;
    @(negedge clk);
    start   = 1'b0;
    product = ~v.product;
    busy_n  = 0;
    done_at = -1;
    cnt_bad = 0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = j;
      if (j < 8 && int'(count) != j) cnt_bad++;
    end
    chk({nm, "_busy_cycles"}, busy_n, 8);
    chk({nm, "_done_latency"}, done_at, 8);
    chk({nm, "_count_seq"}, cnt_bad, 0);
    chk({nm, "_count_end"}, int'(count), 0);
    chk_out(nm, int'(v.sign), int'(v.hund), int'(v.tens), int'(v.ones));
    @(negedge clk);
    chk({nm, "_done_drop"}, int'(done), 0);
    chk_out({nm, "_hold"}, int'(v.sign), int'(v.hund), int'(v.tens), int'(v.ones));
  endtask

  initial begin
    int n_done;
    int gap;
    int hit;
    checks   = 0;
    failures = 0;
    vecs[0]  = '{8'd20,  1'b0, 4'd0, 4'd2, 4'd0};
    vecs[1]  = '{8'hF2,  1'b1, 4'd0, 4'd1, 4'd4};
    vecs[2]  = '{8'd16,  1'b0, 4'd0, 4'd1, 4'd6};
    vecs[3]  = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0};
    vecs[4]  = '{8'h80,  1'b1, 4'd1, 4'd2, 4'd8};
    vecs[5]  = '{8'd127, 1'b0, 4'd1, 4'd2, 4'd7};
    vecs[6]  = '{8'd64,  1'b0, 4'd0, 4'd6, 4'd4};
    vecs[7]  = '{8'hC8,  1'b1, 4'd0, 4'd5, 4'd6};
    vecs[8]  = '{8'hFF,  1'b1, 4'd0, 4'd0, 4'd1};
    vecs[9]  = '{8'd99,  1'b0, 4'd0, 4'd9, 4'd9};
    vecs[10] = '{8'd100, 1'b0, 4'd1, 4'd0, 4'd0};
    vecs[11] = '{8'd1,   1'b0, 4'd0, 4'd0, 4'd1};

    // reset
    reset   = 1'b1;
    start   = 1'b0;
    product = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk_out("rst", 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // start while busy is ignored
    @(negedge clk);
    start   = 1'b1;
    product = 8'd20;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start   = 1'b1;
    product = 8'hF2;
    @(negedge clk);
    start   = 1'b0;
    n_done  = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk_out("busy_start", 0, 0, 2, 0);
      end
    end
    chk("busy_start_dones", n_done, 1);

    // start held high: back-to-back conversions every 9 cycles
    @(negedge clk);
    start   = 1'b1;
    product = 8'd64;
    hit = 0;
    for (int j = 0; j < 12 && !hit; j++) begin
      @(negedge clk);
      if (done) hit = 1;
    end
    chk("b2b_first_done", hit, 1);
    for (int r = 0; r < 2; r++) begin
      gap = 0;
      hit = 0;
      for (int j = 0; j < 15 && !hit; j++) begin
        @(negedge clk);
        gap++;
        if (done) hit = 1;
      end
      chk($sformatf("b2b_gap%0d", r), gap, 9);
      chk_out($sformatf("b2b%0d", r), 0, 0, 6, 4);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // reset mid-conversion; previous outputs are 0/6/4
    start   = 1'b1;
    product = 8'd127;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", int'(busy), 0);
    chk("mid_count", int'(count), 0);
    chk_out("mid", 0, 0, 0, 0);
    n_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("mid_no_done", n_done, 0);

    // reset wins over start on the same edge
    start   = 1'b1;
    reset   = 1'b1;
    product = 8'd20;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("prio_busy", int'(busy), 0);
    @(negedge clk);
    chk("prio_busy_next", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
